// File: rtl/rotation_pkg.sv
// Shared types for the rotation theta sequencer: controller states and the
// default angle width used when no other resolution is configured.
package rotation_pkg;

    localparam int DEFAULT_ROT_RES = 256;
    localparam int THETA_W         = $clog2(DEFAULT_ROT_RES);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        LOCKED   = 2'd2
    } rot_state_e;

endpackage

// File: rtl/rotation_theta_sequencer_if.sv
// Sensor-side inputs and angle/status outputs of the theta sequencer.
// The slave modport is the sequencer; the master modport is its user.
interface rotation_theta_sequencer_if #(
    parameter int THETA_W  = rotation_pkg::THETA_W,
    parameter int PERIOD_W = 24
);
    logic                enable;
    logic                hall_in;
    logic [THETA_W-1:0]  dtheta;
    logic                theta_strobe;
    logic                locked;
    logic                stall;
    logic [PERIOD_W-1:0] period_out;

    modport master (
        output enable, hall_in,
        input  dtheta, theta_strobe, locked, stall, period_out
    );

    modport slave (
        input  enable, hall_in,
        output dtheta, theta_strobe, locked, stall, period_out
    );
endinterface

// File: rtl/hall_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Usable for any slow asynchronous rotor sensor.
module hall_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/rotation_theta_sequencer.sv
// Measures the rotor period from the hall index and steps dtheta through
// ROTATIONAL_RES equal slices per revolution, with lock and stall status.
module rotation_theta_sequencer
    import rotation_pkg::*;
#(
    parameter int ROTATIONAL_RES = 256,
    parameter int PERIOD_W       = 24,
    parameter int MIN_PERIOD     = 1024,
    parameter int MAX_PERIOD     = 12000000
) (
    input logic clk_in,
    input logic rst_in,
    rotation_theta_sequencer_if.slave bus
);
    localparam int                  TW        = $clog2(ROTATIONAL_RES);
    localparam logic [PERIOD_W:0]   MIN_P     = (PERIOD_W+1)'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P     = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE       = PERIOD_W'(1);
    localparam logic [TW-1:0]       THETA_MAX = TW'(ROTATIONAL_RES - 1);

    logic edge_ev;

    hall_edge_detect u_edge (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .sig_i  (bus.hall_in),
        .rise_o (edge_ev)
    );

    rot_state_e          state_q;
    logic [PERIOD_W-1:0] period_cnt_q;
    logic [PERIOD_W-1:0] slice_cnt_q;
    logic [PERIOD_W-1:0] slice_len_q;
    logic [PERIOD_W-1:0] period_out_q;
    logic [TW-1:0]       dtheta_q;
    logic                strobe_q;
    logic                locked_q;
    logic                stall_q;

    logic [PERIOD_W-1:0] meas_period;
    logic                accept;
    logic                timeout;
    logic                slice_wrap;

    // The first edge after unlock is always taken; later ones must clear the holdoff.
    always_comb begin
        meas_period = period_cnt_q + ONE;
        accept      = edge_ev && bus.enable &&
                      ((state_q == UNLOCKED) || (({1'b0, period_cnt_q} + {1'b0, ONE}) >= MIN_P));
        timeout     = (state_q != UNLOCKED) && (period_cnt_q == MAX_P);
        slice_wrap  = (slice_cnt_q == slice_len_q - ONE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= UNLOCKED;
            period_cnt_q <= '0;
            slice_cnt_q  <= '0;
            slice_len_q  <= '0;
            period_out_q <= '0;
            dtheta_q     <= '0;
            strobe_q     <= 1'b0;
            locked_q     <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (period_cnt_q != MAX_P) begin
                period_cnt_q <= period_cnt_q + ONE;
            end

            if (!bus.enable) begin
                state_q     <= UNLOCKED;
                locked_q    <= 1'b0;
                dtheta_q    <= '0;
                slice_cnt_q <= '0;
            end else if (accept) begin
                period_cnt_q <= '0;
                stall_q      <= 1'b0;
                case (state_q)
                    UNLOCKED: state_q <= MEASURE;
                    default: begin
                        state_q      <= LOCKED;
                        locked_q     <= 1'b1;
                        period_out_q <= meas_period;
                        slice_len_q  <= meas_period >> TW;
                        slice_cnt_q  <= '0;
                        dtheta_q     <= '0;
                        strobe_q     <= 1'b1;
                    end
                endcase
            end else if (timeout) begin
                state_q     <= UNLOCKED;
                locked_q    <= 1'b0;
                dtheta_q    <= '0;
                slice_cnt_q <= '0;
                stall_q     <= 1'b1;
            end else if (state_q == LOCKED) begin
                // Past the last slice the angle parks until the next index edge.
                if (slice_wrap) begin
                    slice_cnt_q <= '0;
                    if (dtheta_q != THETA_MAX) begin
                        dtheta_q <= dtheta_q + TW'(1);
                        strobe_q <= 1'b1;
                    end
                end else begin
                    slice_cnt_q <= slice_cnt_q + ONE;
                end
            end
        end
    end

    assign bus.dtheta       = dtheta_q;
    assign bus.theta_strobe = strobe_q;
    assign bus.locked       = locked_q;
    assign bus.stall        = stall_q;
    assign bus.period_out   = period_out_q;
endmodule

// File: tb/tb_rotation_theta_sequencer.sv
// Bench for rotation_theta_sequencer with RES=8, MIN=16, MAX=1000, checked
// every cycle against a revolution-level reference model.
module tb_rotation_theta_sequencer;
    localparam int RES  = 8;
    localparam int PW   = 24;
    localparam int MINP = 16;
    localparam int MAXP = 1000;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    rotation_theta_sequencer_if #(.THETA_W(3), .PERIOD_W(PW)) bus ();

    rotation_theta_sequencer #(
        .ROTATIONAL_RES (RES),
        .PERIOD_W       (PW),
        .MIN_PERIOD     (MINP),
        .MAX_PERIOD     (MAXP)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int step   = 0;

    // Reference model: tracks times of accepted index edges and derives the
    // angle from elapsed cycles since lock divided by the slice length.
    int        cyc = 0, c_acc = 0, c_lock = 0, m_st = 0, slen = 1, m_dtheta = 0;
    bit        m_strobe = 0, m_locked = 0, m_stall = 0;
    logic [23:0] m_period = '0;
    bit        sh [4] = '{default: 1'b0};

    always @(posedge clk_in) begin : model
        bit ev;
        int el, k;
        cyc++;
        ev = sh[2] && !sh[3];
        if (rst_in) begin
            sh = '{default: 1'b0};
            c_acc = cyc; m_st = 0; m_dtheta = 0; m_strobe = 0;
            m_locked = 0; m_stall = 0; m_period = '0;
        end else begin
            sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = bus.hall_in;
            el = cyc - c_acc;
            m_strobe = 0;
            if (!bus.enable) begin
                m_st = 0; m_dtheta = 0; m_locked = 0;
            end else if (ev && (m_st == 0 || el >= MINP)) begin
                c_acc = cyc; m_stall = 0;
                if (m_st == 0) m_st = 1;
                else begin
                    m_st = 2; m_locked = 1; m_period = 24'(el);
                    slen = el / RES; c_lock = cyc; m_dtheta = 0; m_strobe = 1;
                end
            end else if (m_st != 0 && el - 1 >= MAXP) begin
                m_st = 0; m_locked = 0; m_dtheta = 0; m_stall = 1;
            end else if (m_st == 2) begin
                k = cyc - c_lock;
                m_dtheta = (k / slen > RES - 1) ? RES - 1 : k / slen;
                m_strobe = (k % slen == 0) && (k / slen <= RES - 1);
            end
        end
    end

    function automatic logic [29:0] obs();
        return {bus.dtheta, bus.theta_strobe, bus.locked, bus.stall, bus.period_out};
    endfunction

    function automatic logic [29:0] expv();
        return {3'(m_dtheta), m_strobe, m_locked, m_stall, m_period};
    endfunction

    task automatic drive_cycle(input logic h);
        bus.hall_in = h;
        @(posedge clk_in);
        @(negedge clk_in);
        step++;
    endtask

    task automatic test_reset();
        int strobes = 0;
        rst_in = 1'b1; bus.enable = 1'b0;
        repeat (3) drive_cycle(1'b0);
        checks++;
        if (obs() !== 30'd0) begin
            errors++; $display("FAIL reset_state got=%h want=%h", obs(), 30'd0);
        end
        rst_in = 1'b0; bus.enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL idle step=%0d got=%h want=%h", step, obs(), expv());
            end
            strobes += int'(bus.theta_strobe);
        end
        checks++;
        if ({bus.locked, bus.stall, bus.dtheta} !== 5'd0 || strobes != 0) begin
            errors++; $display("FAIL idle_quiet got l=%b st=%b d=%0d strobes=%0d want all 0", bus.locked, bus.stall, bus.dtheta, strobes);
        end
    endtask

    task automatic test_lock80();
        int ps2 = 0, lock_step = -1, strobes = 0;
        for (int p = 0; p < 4; p++) begin
            if (p == 1) ps2 = step + 1;
            for (int i = 0; i < 80; i++) begin
                drive_cycle(i < 2);
                checks++;
                if (obs() !== expv()) begin
                    errors++; $display("FAIL lock80 step=%0d got=%h want=%h", step, obs(), expv());
                end
                if (bus.locked && lock_step < 0) lock_step = step;
                if (p == 2) strobes += int'(bus.theta_strobe);
            end
        end
        checks++;
        if (lock_step - ps2 != 3) begin
            errors++; $display("FAIL lock_latency got=%0d want=3", lock_step - ps2);
        end
        checks++;
        if (strobes != 8) begin
            errors++; $display("FAIL strobes_per_rev got=%0d want=8", strobes);
        end
        checks++;
        if (bus.period_out !== 24'd80) begin
            errors++; $display("FAIL period80 got=%0d want=80", bus.period_out);
        end
    endtask

    task automatic test_saturate();
        int sa = 0, sb = 0, pb = 0;
        logic [2:0] d14 = '0, d15 = '0;
        for (int i = 0; i < 120; i++) begin
            drive_cycle(i < 2);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL sat_a step=%0d got=%h want=%h", step, obs(), expv());
            end
            sa += int'(bus.theta_strobe);
        end
        checks++;
        if (sa != 8 || bus.dtheta !== 3'd7) begin
            errors++; $display("FAIL saturate got strobes=%0d d=%0d want strobes=8 d=7", sa, bus.dtheta);
        end
        pb = step + 1;
        for (int i = 0; i < 120; i++) begin
            drive_cycle(i < 2);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL sat_b step=%0d got=%h want=%h", step, obs(), expv());
            end
            sb += int'(bus.theta_strobe);
            if (step == pb + 17) d14 = bus.dtheta;
            if (step == pb + 18) d15 = bus.dtheta;
        end
        checks++;
        if (bus.period_out !== 24'd120 || sb != 8) begin
            errors++; $display("FAIL period120 got p=%0d strobes=%0d want p=120 strobes=8", bus.period_out, sb);
        end
        checks++;
        if (d14 !== 3'd0 || d15 !== 3'd1) begin
            errors++; $display("FAIL slice_len15 got d14=%0d d15=%0d want 0 1", d14, d15);
        end
    endtask

    task automatic test_glitch();
        int strobes = 0;
        logic [2:0] d10 = '1;
        logic [23:0] p10 = '0;
        for (int i = 0; i < 120; i++) begin
            drive_cycle(i < 2 || i == 5);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL glitch step=%0d got=%h want=%h", step, obs(), expv());
            end
            strobes += int'(bus.theta_strobe);
            if (i == 10) begin d10 = bus.dtheta; p10 = bus.period_out; end
        end
        checks++;
        if (d10 !== 3'd0 || p10 !== 24'd120 || strobes != 8) begin
            errors++; $display("FAIL glitch_ignored got d=%0d p=%0d strobes=%0d want d=0 p=120 strobes=8", d10, p10, strobes);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int per = $urandom_range(150, 20);
            int w   = $urandom_range(3, 1);
            int g   = $urandom_range(per - 2, w + 1);
            bit gl  = ($urandom_range(2, 0) == 0);
            for (int i = 0; i < per; i++) begin
                bus.enable = ($urandom_range(299, 0) != 0);
                drive_cycle(i < w || (gl && i == g));
                checks++;
                if (obs() !== expv()) begin
                    errors++; $display("FAIL random rev=%0d step=%0d got=%h want=%h", r, step, obs(), expv());
                end
            end
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_timeout();
        int ps = 0, fall_step = -1;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 80; i++) begin
                drive_cycle(i < 2);
                checks++;
                if (obs() !== expv()) begin
                    errors++; $display("FAIL to_lock step=%0d got=%h want=%h", step, obs(), expv());
                end
            end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++; $display("FAIL to_locked got=%b want=1", bus.locked);
        end
        ps = step + 1;
        for (int i = 0; i < 1011; i++) begin
            drive_cycle(i < 2);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL timeout step=%0d got=%h want=%h", step, obs(), expv());
            end
            if (!bus.locked && fall_step < 0) fall_step = step;
        end
        checks++;
        if (fall_step - ps != 1004 || {bus.locked, bus.stall, bus.dtheta} !== 5'b01000) begin
            errors++; $display("FAIL stall got fall=%0d l=%b st=%b d=%0d want fall=1004 l=0 st=1 d=0", fall_step - ps, bus.locked, bus.stall, bus.dtheta);
        end
        bus.enable = 1'b0;
        drive_cycle(1'b0);
        bus.enable = 1'b1;
        checks++;
        if (bus.stall !== 1'b1 || bus.period_out !== 24'd80 || bus.locked !== 1'b0) begin
            errors++; $display("FAIL enable_hold got st=%b p=%0d l=%b want st=1 p=80 l=0", bus.stall, bus.period_out, bus.locked);
        end
        for (int i = 0; i < 80; i++) begin
            drive_cycle(i < 2);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL restart step=%0d got=%h want=%h", step, obs(), expv());
            end
            if (i == 5 && (bus.stall !== 1'b0 || bus.locked !== 1'b0)) begin
                errors++; $display("FAIL stall_clear got st=%b l=%b want st=0 l=0", bus.stall, bus.locked);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 5; p++) begin
            int len = (p == 2) ? 25 : 80;
            if (p == 3) begin
                rst_in = 1'b1;
                drive_cycle(1'b0);
                rst_in = 1'b0;
                checks++;
                if (obs() !== 30'd0) begin
                    errors++; $display("FAIL reset_mid got=%h want=%h", obs(), 30'd0);
                end
            end
            if (p == 4) len = 20;
            for (int i = 0; i < len; i++) begin
                drive_cycle(i < 2);
                checks++;
                if (obs() !== expv()) begin
                    errors++; $display("FAIL reset_seq p=%0d step=%0d got=%h want=%h", p, step, obs(), expv());
                end
            end
            if (p == 3) begin
                checks++;
                if (bus.locked !== 1'b0) begin
                    errors++; $display("FAIL relock_one_pulse got=%b want=0", bus.locked);
                end
            end
        end
        checks++;
        if (bus.locked !== 1'b1 || bus.period_out !== 24'd80) begin
            errors++; $display("FAIL relock got l=%b p=%0d want l=1 p=80", bus.locked, bus.period_out);
        end
        bus.enable = 1'b0;
        drive_cycle(1'b0);
        bus.enable = 1'b1;
        checks++;
        if ({bus.dtheta, bus.theta_strobe, bus.locked, bus.stall} !== 6'd0 || bus.period_out !== 24'd80) begin
            errors++; $display("FAIL enable_drop got=%h want d=0 s=0 l=0 st=0 p=80", obs());
        end
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 80; i++) begin
                drive_cycle(i < 2);
                checks++;
                if (obs() !== expv()) begin
                    errors++; $display("FAIL en_relock step=%0d got=%h want=%h", step, obs(), expv());
                end
            end
            checks++;
            if (bus.locked !== (p == 1)) begin
                errors++; $display("FAIL en_relock_lock pulse=%0d got=%b want=%b", p + 1, bus.locked, p == 1);
            end
        end
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.hall_in = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_lock80();
        test_saturate();
        test_glitch();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog step=%0d did not reach the end", step);
        $fatal(1);
    end
endmodule
